wdg_heartbeat_tx: RTL

//   Transmit end of the watchdog heartbeat link: drives a square-wave line (wdg) whose

---
 rtl/wdg_heartbeat_tx_if.sv | 27 ++
 rtl/wdg_heartbeat_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/wdg_heartbeat_tx_if.sv
// Heartbeat link bundle: enable/kick towards the transmitter, line and status back.
interface wdg_heartbeat_tx_if;
  logic en;
  logic kick;
  logic wdg;
  logic wdg_edge;
  logic running;
  logic stalled;

  modport master (
    output en,
    output kick,
    input  wdg,
    input  wdg_edge,
    input  running,
    input  stalled
  );

  modport slave (
    input  en,
    input  kick,
    output wdg,
    output wdg_edge,
    output running,
    output stalled
  );
endinterface

// File: rtl/wdg_heartbeat_tx.sv
// Watchdog heartbeat transmitter: toggles wdg every HALF_PERIOD cycles while kicks
// keep arriving; freezes the line (STALL) after MAX_MISS kick-less half-periods.
module wdg_heartbeat_tx #(
  parameter int unsigned HALF_PERIOD = 1000,
  parameter int unsigned MAX_MISS    = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned MISS_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  wdg_heartbeat_tx_if.slave  hb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0]  DIV_TC   = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LIM  = DIV_W'(HALF_PERIOD);
  localparam logic [MISS_W-1:0] MISS_LST = MISS_W'(MAX_MISS - 1);

  state_e              state_q, state_d;
  logic                wdg_q, wdg_d;
  logic                edge_q, edge_d;
  logic                running_q, running_d;
  logic                stalled_q, stalled_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                kick_seen_q, kick_seen_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wdg_q       <= 1'b0;
      edge_q      <= 1'b0;
      running_q   <= 1'b0;
      stalled_q   <= 1'b0;
      div_q       <= '0;
      miss_q      <= '0;
      kick_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdg_q       <= wdg_d;
      edge_q      <= edge_d;
      running_q   <= running_d;
      stalled_q   <= stalled_d;
      div_q       <= div_d;
      miss_q      <= miss_d;
      kick_seen_q <= kick_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wdg_d       = wdg_q;
    edge_d      = 1'b0;
    div_d       = div_q;
    miss_d      = miss_q;
    kick_seen_d = kick_seen_q;

    if (!hb.en) begin
      state_d     = IDLE;
      div_d       = '0;
      miss_d      = '0;
      kick_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = RUN;
          div_d       = '0;
          miss_d      = '0;
          kick_seen_d = 1'b0;
        end

        RUN: begin
          if (div_q == DIV_TC) begin
            div_d       = '0;
            kick_seen_d = 1'b0;
            // A kick landing on the terminal cycle still counts for this half-period.
            if (kick_seen_q || hb.kick) begin
              wdg_d  = ~wdg_q;
              edge_d = 1'b1;
              miss_d = '0;
            end else if (miss_q == MISS_LST) begin
              miss_d  = '0;
              state_d = STALL;
            end else begin
              wdg_d  = ~wdg_q;
              edge_d = 1'b1;
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            div_d       = div_q + DIV_W'(1);
            kick_seen_d = kick_seen_q | hb.kick;
          end
        end

        STALL: begin
          div_d = '0;
          if (hb.kick) begin
            state_d     = RUN;
            miss_d      = '0;
            kick_seen_d = 1'b0;
          end
        end

        default: begin
          state_d     = IDLE;
          div_d       = '0;
          miss_d      = '0;
          kick_seen_d = 1'b0;
        end
      endcase
    end

    running_d = (state_d == RUN);
    stalled_d = (state_d == STALL);
  end

  assign hb.wdg      = wdg_q;
  assign hb.wdg_edge = edge_q;
  assign hb.running  = running_q;
  assign hb.stalled  = stalled_q;

  a_status_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(running_q && stalled_q));

  a_edge_means_toggle : assert property (@(posedge clk) disable iff (!rst)
    edge_q |-> (wdg_q != $past(wdg_q)));

  a_div_bounded : assert property (@(posedge clk) disable iff (!rst)
    div_q < DIV_LIM);

endmodule
